mem_xfer_seq: RTL and testbench

MEM_XFER_SEQ -- requirements
Module: mem_xfer_seq

---
 rtl/mem_xfer_seq_if.sv | 36 +++
 rtl/mem_xfer_seq.sv | 145 ++++++++++++++
 tb/tb_mem_xfer_seq.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_xfer_seq_if.sv
// Bus bundle for mem_xfer_seq: control, source-memory read port, FIFO push/pop ports,
// destination-memory write port and status.
interface mem_xfer_seq_if #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 4
);
    logic          start;
    logic          abort;
    logic          src_re;
    logic [AW-1:0] src_addr;
    logic [DW-1:0] src_rdata;
    logic          fifo_wr_en;
    logic [DW-1:0] fifo_wdata;
    logic          fifo_full;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_rdata;
    logic          fifo_empty;
    logic          dst_we;
    logic [AW-1:0] dst_addr;
    logic [DW-1:0] dst_wdata;
    logic          busy;
    logic          done;
    logic [DW-1:0] checksum;

    modport master (
        input  start, abort, src_rdata, fifo_full, fifo_rdata, fifo_empty,
        output src_re, src_addr, fifo_wr_en, fifo_wdata, fifo_rd_en,
               dst_we, dst_addr, dst_wdata, busy, done, checksum
    );

    modport slave (
        output start, abort, src_rdata, fifo_full, fifo_rdata, fifo_empty,
        input  src_re, src_addr, fifo_wr_en, fifo_wdata, fifo_rd_en,
               dst_we, dst_addr, dst_wdata, busy, done, checksum
    );
endinterface

// File: rtl/mem_xfer_seq.sv
// Moves DEPTH words source memory -> FIFO -> destination memory through a 1-entry skid.
// Optional running checksum of written words: define MEM_XFER_SEQ_CHECKSUM_EN.
module mem_xfer_seq #(
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input logic           clk,
    input logic           rst,
    mem_xfer_seq_if.master bus
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    localparam logic [AW:0] DepthCnt = (AW + 1)'(DEPTH);

    state_e        state_q, state_d;
    logic [AW:0]   src_cnt_q, src_cnt_d;
    logic [AW:0]   iss_cnt_q, iss_cnt_d;
    logic [AW:0]   dst_cnt_q, dst_cnt_d;
    logic          rd_pend_q, rd_pend_d;
    logic          skid_vld_q, skid_vld_d;
    logic [DW-1:0] skid_q, skid_d;
    logic          pop_q, pop_d;

    logic run, launch, kill, drop, last_wr;
    logic src_re, fifo_wr_en, fifo_rd_en;

    always_comb begin
        run        = (state_q == StRun);
        launch     = (state_q == StIdle) && bus.start;
        kill       = run && bus.abort;
        src_re     = run && !bus.abort && (src_cnt_q < DepthCnt) &&
                     (!skid_vld_q || !bus.fifo_full);
        fifo_wr_en = skid_vld_q && !bus.fifo_full;
        fifo_rd_en = run && !bus.abort && !bus.fifo_empty && (iss_cnt_q < DepthCnt);
        // Returning read data with the skid held by a full FIFO is dropped and re-read.
        drop       = rd_pend_q && skid_vld_q && bus.fifo_full;
        last_wr    = pop_q && (dst_cnt_q == DepthCnt - 1'b1);

        state_d    = state_q;
        src_cnt_d  = src_cnt_q;
        iss_cnt_d  = iss_cnt_q;
        dst_cnt_d  = dst_cnt_q;
        skid_vld_d = skid_vld_q;
        skid_d     = skid_q;
        rd_pend_d  = src_re;
        pop_d      = fifo_rd_en;

        if (fifo_wr_en) begin
            skid_vld_d = 1'b0;
        end
        if (rd_pend_q && !drop) begin
            skid_vld_d = 1'b1;
            skid_d     = bus.src_rdata;
        end

        if (src_re) begin
            src_cnt_d = src_cnt_q + 1'b1;
        end else if (drop) begin
            src_cnt_d = src_cnt_q - 1'b1;
        end
        if (fifo_rd_en) begin
            iss_cnt_d = iss_cnt_q + 1'b1;
        end
        if (pop_q) begin
            dst_cnt_d = dst_cnt_q + 1'b1;
        end

        unique case (state_q)
            StIdle: if (bus.start) state_d = StRun;
            StRun: begin
                if (bus.abort) begin
                    state_d = StIdle;
                end else if (last_wr) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (launch || kill) begin
            skid_vld_d = 1'b0;
            skid_d     = '0;
        end
        if (launch) begin
            src_cnt_d = '0;
            iss_cnt_d = '0;
            dst_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            src_cnt_q  <= '0;
            iss_cnt_q  <= '0;
            dst_cnt_q  <= '0;
            rd_pend_q  <= 1'b0;
            skid_vld_q <= 1'b0;
            skid_q     <= '0;
            pop_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            src_cnt_q  <= src_cnt_d;
            iss_cnt_q  <= iss_cnt_d;
            dst_cnt_q  <= dst_cnt_d;
            rd_pend_q  <= rd_pend_d;
            skid_vld_q <= skid_vld_d;
            skid_q     <= skid_d;
            pop_q      <= pop_d;
        end
    end

`ifdef MEM_XFER_SEQ_CHECKSUM_EN
    logic [DW-1:0] sum_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q <= '0;
        end else if (launch) begin
            sum_q <= '0;
        end else if (pop_q) begin
            sum_q <= sum_q + bus.fifo_rdata;
        end
    end

    assign bus.checksum = sum_q;
`else
    assign bus.checksum = '0;
`endif

    assign bus.src_re     = src_re;
    assign bus.src_addr   = src_cnt_q[AW-1:0];
    assign bus.fifo_wr_en = fifo_wr_en;
    assign bus.fifo_wdata = skid_q;
    assign bus.fifo_rd_en = fifo_rd_en;
    assign bus.dst_we     = pop_q;
    assign bus.dst_addr   = dst_cnt_q[AW-1:0];
    assign bus.dst_wdata  = pop_q ? bus.fifo_rdata : '0;
    assign bus.busy       = run;
    assign bus.done       = (state_q == StDone);

endmodule

// File: tb/tb_mem_xfer_seq.sv
// Directed bench for mem_xfer_seq with a sync source RAM, 4-deep FIFO and destination RAM model.
module tb_mem_xfer_seq;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_xfer_seq_if #(.DW(8), .AW(4)) bus ();

    mem_xfer_seq #(.DW(8), .DEPTH(16), .AW(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0] src_mem [16];
    logic [7:0] dst_mem [16];
    logic [7:0] fq [$];
    logic       full_r, empty_r;
    logic       force_full, force_empty, model_clr;
    int         wr_cnt, done_cnt, push_viol, pop_viol, addr_viol;
    int         n_vec = 0;
    int         n_bad = 0;
    logic [7:0] exp_sum;

    assign bus.fifo_full  = full_r | force_full;
    assign bus.fifo_empty = empty_r | force_empty;

    // Memory/FIFO models sample DUT outputs before its registers update on the same edge.
    always @(posedge clk) begin
        if (rst || model_clr) begin
            fq.delete();
            full_r         <= 1'b0;
            empty_r        <= 1'b1;
            bus.src_rdata  <= '0;
            bus.fifo_rdata <= '0;
            wr_cnt         <= 0;
            done_cnt       <= 0;
            push_viol      <= 0;
            pop_viol       <= 0;
            addr_viol      <= 0;
            for (int i = 0; i < 16; i++) dst_mem[i] <= 8'h00;
        end else begin
            if (bus.src_re) bus.src_rdata <= src_mem[bus.src_addr];
            if (bus.fifo_rd_en) begin
                if (bus.fifo_empty) pop_viol <= pop_viol + 1;
                if (fq.size() > 0) bus.fifo_rdata <= fq.pop_front();
            end
            if (bus.fifo_wr_en) begin
                if (bus.fifo_full) push_viol <= push_viol + 1;
                fq.push_back(bus.fifo_wdata);
            end
            full_r  <= (fq.size() >= 4);
            empty_r <= (fq.size() == 0);
            if (bus.dst_we) begin
                if (32'(bus.dst_addr) != wr_cnt) addr_viol <= addr_viol + 1;
                dst_mem[bus.dst_addr] <= bus.dst_wdata;
                wr_cnt <= wr_cnt + 1;
            end
            if (bus.done) done_cnt <= done_cnt + 1;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic clear_model();
        @(negedge clk);
        model_clr = 1'b1;
        @(negedge clk);
        model_clr = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        logic seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done_cnt > 0) begin
                seen = 1'b1;
                break;
            end
        end
        check_val({tag, "_done_seen"}, 32'(seen), 1);
        repeat (4) @(negedge clk);
    endtask

    task automatic check_xfer(input string tag);
        check_val({tag, "_writes"}, wr_cnt, 16);
        check_val({tag, "_done_pulses"}, done_cnt, 1);
        check_val({tag, "_push_while_full"}, push_viol, 0);
        check_val({tag, "_pop_while_empty"}, pop_viol, 0);
        check_val({tag, "_addr_order"}, addr_viol, 0);
        check_val({tag, "_busy_after"}, 32'(bus.busy), 0);
        check_val({tag, "_checksum"}, 32'(bus.checksum), 32'(exp_sum));
        for (int i = 0; i < 16; i++)
            check_val($sformatf("%s_dst%0d", tag, i), 32'(dst_mem[i]), 32'(src_mem[i]));
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_busy"}, 32'(bus.busy), 0);
        check_val({tag, "_done"}, 32'(bus.done), 0);
        check_val({tag, "_src_re"}, 32'(bus.src_re), 0);
        check_val({tag, "_src_addr"}, 32'(bus.src_addr), 0);
        check_val({tag, "_fifo_wr_en"}, 32'(bus.fifo_wr_en), 0);
        check_val({tag, "_fifo_wdata"}, 32'(bus.fifo_wdata), 0);
        check_val({tag, "_fifo_rd_en"}, 32'(bus.fifo_rd_en), 0);
        check_val({tag, "_dst_we"}, 32'(bus.dst_we), 0);
        check_val({tag, "_dst_addr"}, 32'(bus.dst_addr), 0);
        check_val({tag, "_dst_wdata"}, 32'(bus.dst_wdata), 0);
        check_val({tag, "_checksum"}, 32'(bus.checksum), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic hit;
        src_mem = '{8'd4, 8'd14, 8'd24, 8'd42, 8'd141, 8'd243, 8'd41, 8'd134,
                    8'd204, 8'd124, 8'd104, 8'd24, 8'd34, 8'd74, 8'd84, 8'd95};
`ifdef MEM_XFER_SEQ_CHECKSUM_EN
        exp_sum = 8'h6A;  // 1386 mod 256
`else
        exp_sum = 8'h00;
`endif
        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.abort   = 1'b0;
        force_full  = 1'b0;
        force_empty = 1'b0;
        model_clr   = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // Ideal FIFO
        clear_model();
        pulse_start();
        wait_done("ideal", 200);
        check_xfer("ideal");

        // FIFO full for 5 cycles mid-transfer
        clear_model();
        pulse_start();
        repeat (6) @(negedge clk);
        force_full = 1'b1;
        repeat (5) @(negedge clk);
        force_full = 1'b0;
        wait_done("full5", 200);
        check_xfer("full5");

        // FIFO empty for 10 cycles from start
        clear_model();
        @(negedge clk);
        bus.start   = 1'b1;
        force_empty = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        force_empty = 1'b0;
        wait_done("empty10", 300);
        check_xfer("empty10");

        // Abort after 6 destination writes, then a fresh transfer
        clear_model();
        pulse_start();
        hit = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (wr_cnt >= 6) begin
                hit = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check_val("abort_reach6", 32'(hit), 1);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check_val("abort_idle_next", 32'(bus.busy), 0);
        repeat (5) @(negedge clk);
        check_val("abort_no_done", done_cnt, 0);
        check_val("abort_partial", 32'(wr_cnt < 16), 1);
        clear_model();
        pulse_start();
        wait_done("after_abort", 200);
        check_xfer("after_abort");

        // Start re-pulsed during RUN
        clear_model();
        pulse_start();
        repeat (4) @(negedge clk);
        pulse_start();
        repeat (3) @(negedge clk);
        pulse_start();
        wait_done("restart", 200);
        repeat (4) @(negedge clk);
        check_xfer("restart");

        // Reset mid-transfer
        clear_model();
        pulse_start();
        repeat (8) @(negedge clk);
        check_val("rst_mid_busy_before", 32'(bus.busy), 1);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("rst_mid");
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check_val("rst_idle_busy", 32'(bus.busy), 0);
        check_val("rst_idle_no_done", done_cnt, 0);
        check_val("rst_idle_no_write", wr_cnt, 0);
        clear_model();
        pulse_start();
        wait_done("after_rst", 200);
        check_xfer("after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
